multi_byte_sender: RTL and testbench
====================================

# multi_byte_sender

Parametrised successor to the single-byte sample responder. On an `activate`/`done` handshake it captures a multi-byte value and transmits it over the UART transmitter's `tx_start`/`tx_active` handshake, one byte per handshake. Byte order is selectable, and an XOR checksum byte can optionally be appended. A transmitter that never acknowledges is detected by a timeout. The block sits between the command decoder and the shared UART TX.

## Interface
- `BYTES`, default 4: number of data bytes sent per activation; must be at least 1.
- `MSB_FIRST`, default 1: 1 sends `value[8*BYTES-1 -: 8]` first; 0 sends `value[7:0]` first.
- `APPEND_CSUM`, default 0: 1 appends one XOR checksum byte after the data bytes.
- `ACK_TIMEOUT`, default 1024: maximum number of cycles to wait for `tx_active` after raising `tx_start`; 0 disables the timeout.

Ports (name, direction, width, meaning):
- `clk_50mhz`, in, 1: the only clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `activate`, in, 1: held at 1 to request a transfer.
- `done`, out, 1: transfer finished, successfully or aborted.
- `error`, out, 1: the transfer was aborted by timeout; valid while `done`=1.
- `tx_active`, in, 1: the UART transmitter is busy.
- `tx_data`, out, 8: byte currently offered to the transmitter.
- `tx_start`, out, 1: request to the transmitter to send `tx_data`.
- `value`, in, 8*`BYTES`: data to send; sampled only at acceptance.

## Operation
- All outputs are registered.
- Reset values: `done`=0, `error`=0, `tx_start`=0, `tx_data`=0, state=`ST_IDLE`, byte counter=0, checksum=0, timeout counter=0.
- `ST_IDLE`:
  - `done`=0 and `tx_start`=0.
  - On `activate`=1:
    - latch `value` into the shift register;
    - clear `error` and the checksum;
    - set byte counter=0;
    - drive `tx_data` with the first byte and `tx_start`=1;
    - go to `ST_ACK`.
- `ST_ACK`:
  - `tx_start` stays 1 until `tx_active` is sampled 1.
  - When it is: `tx_start`=0, checksum ^= `tx_data`, go to `ST_BUSY`.
  - The timeout counter increments each cycle in this state.
  - If it reaches `ACK_TIMEOUT` with `ACK_TIMEOUT`≠0: `tx_start`=0, `error`=1, `done`=1, go to `ST_DONE`.
- `ST_BUSY`: wait for `tx_active` sampled 0. Then:
  - If more data bytes remain: increment the counter, load the next byte into `tx_data`, `tx_start`=1, clear the timeout counter, go to `ST_ACK`.
  - Else if `APPEND_CSUM`=1 and the checksum has not been sent: `tx_data`=checksum, `tx_start`=1, go to `ST_ACK`. The checksum byte is not folded into itself.
  - Else: `done`=1, go to `ST_DONE`.
- `ST_DONE`:
  - `done` and `error` are held.
  - When `activate` is sampled 0: `done`=0, go to `ST_IDLE`. `error` is kept until the next acceptance.
- Widths:
  - Byte counter is $clog2(`BYTES`+1) bits.
  - Timeout counter is $clog2(`ACK_TIMEOUT`+1) bits and saturates; it never wraps.
- Invalid or unused state encodings go to `ST_IDLE` with `tx_start`=0.

## Timing
- Acceptance latency: `tx_start` rises 1 cycle after `activate` is first sampled 1 in `ST_IDLE`.
- `tx_data` is stable whenever `tx_start`=1 and until `tx_active` falls.
- Inter-byte gap: the next `tx_start` rises 1 cycle after `tx_active` is sampled 0.
- A `tx_active` that is already 1 on entry to `ST_ACK` is taken as the acknowledge on that same edge.
- `done` rises 1 cycle after the final `tx_active` fall. It falls 1 cycle after `activate` is sampled 0.
- `activate` dropping mid-transfer is ignored. The transfer completes, `done` is high for exactly 1 cycle, then the block returns to `ST_IDLE`.
- `activate` still high in `ST_IDLE` after a transfer is only possible after `done` was seen. Re-raising `activate` starts a new transfer with freshly sampled `value`.
- Changes to `value` during a transfer have no effect on the bytes sent.
- Asynchronous reset mid-transfer forces `tx_start`=0 and all outputs to their reset values immediately. The byte in flight is not retried.

## Test plan
- `BYTES`=4, `MSB_FIRST`=1, `value`=32'h12345678; the transmitter model acknowledges after 2 cycles and stays busy for 10 cycles -> `tx_data` sequence 12,34,56,78; exactly 4 `tx_start` rises; `done`=1 with `error`=0; `done` clears 1 cycle after `activate` falls.
- Same stimulus with `MSB_FIRST`=0 and `APPEND_CSUM`=1 -> sequence 78,56,34,12,08 (checksum = 0x12^0x34^0x56^0x78 = 0x08).
- `ACK_TIMEOUT`=16; `tx_active` held at 0 -> `tx_start` falls, and `done`=1 and `error`=1 exactly 16 cycles after `tx_start` rose; the next activation clears `error`.
- `activate` dropped after byte 1 of 4 -> all 4 bytes are still sent, `done` is high for a single cycle, and the block ends in idle.
- `reset` asserted during `ST_ACK` of byte 2 -> `tx_start`, `done`, `error` and `tx_data` all go to 0 immediately; after release, a new activation sends from byte 1.
- `BYTES`=1 with `tx_active` already high when `tx_start` rises -> the acknowledge is taken on the first `ST_ACK` cycle and the single byte completes normally.

Source files
------------

// File: rtl/multi_byte_sender.sv
// Captures a BYTES-wide value on an activate/done handshake and feeds it byte by byte
// to the shared UART transmitter, optionally closing with an XOR checksum byte.
module multi_byte_sender #(
    parameter int BYTES       = 4,
    parameter int MSB_FIRST   = 1,
    parameter int APPEND_CSUM = 0,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                 clk_50mhz,
    input  logic                 reset,
    input  logic                 activate,
    output logic                 done,
    output logic                 error,
    input  logic                 tx_active,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic [8*BYTES-1:0]   value
);

    localparam int VW     = 8 * BYTES;
    localparam int CNT_W  = $clog2(BYTES + 1);
    localparam int TOUT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BYTES - 1);
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [TOUT_W-1:0] TOUT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_BUSY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // The shift register always holds the bytes not yet offered, next byte at the head.
    function automatic logic [7:0] head_byte(input logic [VW-1:0] v);
        if (MSB_FIRST != 0) return v[VW-1 -: 8];
        else                return v[7:0];
    endfunction

    function automatic logic [VW-1:0] drop_head(input logic [VW-1:0] v);
        if (MSB_FIRST != 0) return v << 8;
        else                return v >> 8;
    endfunction

    state_t              state_reg, state_next;
    logic [VW-1:0]       shift_reg, shift_next;
    logic [CNT_W-1:0]    byte_cnt_reg, byte_cnt_next;
    logic [7:0]          csum_reg, csum_next;
    logic                csum_phase_reg, csum_phase_next;
    logic [TOUT_W-1:0]   tout_reg, tout_next;
    logic [TOUT_W-1:0]   tout_inc;
    logic [7:0]          tx_data_reg, tx_data_next;
    logic                tx_start_reg, tx_start_next;
    logic                done_reg, done_next;
    logic                error_reg, error_next;

    assign tout_inc = (tout_reg == TOUT_MAX) ? tout_reg : tout_reg + 1'b1;

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            shift_reg      <= '0;
            byte_cnt_reg   <= '0;
            csum_reg       <= '0;
            csum_phase_reg <= 1'b0;
            tout_reg       <= '0;
            tx_data_reg    <= '0;
            tx_start_reg   <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            byte_cnt_reg   <= byte_cnt_next;
            csum_reg       <= csum_next;
            csum_phase_reg <= csum_phase_next;
            tout_reg       <= tout_next;
            tx_data_reg    <= tx_data_next;
            tx_start_reg   <= tx_start_next;
            done_reg       <= done_next;
            error_reg      <= error_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        byte_cnt_next   = byte_cnt_reg;
        csum_next       = csum_reg;
        csum_phase_next = csum_phase_reg;
        tout_next       = tout_reg;
        tx_data_next    = tx_data_reg;
        tx_start_next   = tx_start_reg;
        done_next       = done_reg;
        error_next      = error_reg;

        case (state_reg)
            ST_IDLE: begin
                done_next     = 1'b0;
                tx_start_next = 1'b0;
                if (activate) begin
                    tx_data_next    = head_byte(value);
                    shift_next      = drop_head(value);
                    error_next      = 1'b0;
                    csum_next       = '0;
                    csum_phase_next = 1'b0;
                    byte_cnt_next   = '0;
                    tout_next       = '0;
                    tx_start_next   = 1'b1;
                    state_next      = ST_ACK;
                end
            end

            ST_ACK: begin
                tout_next = tout_inc;
                // An acknowledge on the same edge as the timeout wins.
                if (tx_active) begin
                    tx_start_next = 1'b0;
                    if (!csum_phase_reg) csum_next = csum_reg ^ tx_data_reg;
                    state_next = ST_BUSY;
                end else if (ACK_TIMEOUT != 0 && tout_reg == TOUT_LAST) begin
                    tx_start_next = 1'b0;
                    error_next    = 1'b1;
                    done_next     = 1'b1;
                    state_next    = ST_DONE;
                end
            end

            ST_BUSY: begin
                if (!tx_active) begin
                    if (byte_cnt_reg != LAST_IDX) begin
                        byte_cnt_next = byte_cnt_reg + 1'b1;
                        tx_data_next  = head_byte(shift_reg);
                        shift_next    = drop_head(shift_reg);
                        tx_start_next = 1'b1;
                        tout_next     = '0;
                        state_next    = ST_ACK;
                    end else if (APPEND_CSUM != 0 && !csum_phase_reg) begin
                        tx_data_next    = csum_reg;
                        csum_phase_next = 1'b1;
                        tx_start_next   = 1'b1;
                        tout_next       = '0;
                        state_next      = ST_ACK;
                    end else begin
                        done_next  = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (!activate) begin
                    done_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end

            default: begin
                tx_start_next = 1'b0;
                state_next    = ST_IDLE;
            end
        endcase
    end

    assign done     = done_reg;
    assign error    = error_reg;
    assign tx_data  = tx_data_reg;
    assign tx_start = tx_start_reg;

endmodule

// File: tb/tb_multi_byte_sender.sv
// Bench for multi_byte_sender: three configurations driven by a shared UART transmitter
// model, with a byte scoreboard filled at stimulus time and drained on each tx_start rise.
`timescale 1ns/1ps
module tb_multi_byte_sender;

    logic clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    logic            reset;
    logic [2:0]      act = '0;
    logic [2:0]      done_w, err_w, txs;
    logic [2:0]      txa = '0;
    logic [2:0][7:0] txd;
    logic [31:0]     value_a = '0;
    logic [31:0]     value_b = '0;
    logic [7:0]      value_c = '0;

    // 0: 4 bytes MSB first, timeout 16; 1: 4 bytes LSB first + checksum; 2: 1 byte, no timeout
    multi_byte_sender #(.BYTES(4), .MSB_FIRST(1), .APPEND_CSUM(0), .ACK_TIMEOUT(16)) dut_a (
        .clk_50mhz(clk_50mhz), .reset(reset), .activate(act[0]), .done(done_w[0]),
        .error(err_w[0]), .tx_active(txa[0]), .tx_data(txd[0]), .tx_start(txs[0]), .value(value_a));
    multi_byte_sender #(.BYTES(4), .MSB_FIRST(0), .APPEND_CSUM(1), .ACK_TIMEOUT(16)) dut_b (
        .clk_50mhz(clk_50mhz), .reset(reset), .activate(act[1]), .done(done_w[1]),
        .error(err_w[1]), .tx_active(txa[1]), .tx_data(txd[1]), .tx_start(txs[1]), .value(value_b));
    multi_byte_sender #(.BYTES(1), .MSB_FIRST(1), .APPEND_CSUM(0), .ACK_TIMEOUT(0)) dut_c (
        .clk_50mhz(clk_50mhz), .reset(reset), .activate(act[2]), .done(done_w[2]),
        .error(err_w[2]), .tx_active(txa[2]), .tx_data(txd[2]), .tx_start(txs[2]), .value(value_c));

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         inst;
        logic [7:0] data;
    } sb_t;
    sb_t exp_q[$];
    sb_t sb_e;

    typedef struct {
        int              inst;
        logic [31:0]     value;
        int              mode;   // 0 normal, 1 never ack, 2 tx_active already high
        int              ack;
        int              busy;
        int              n;
        logic [0:4][7:0] b;
    } vec_t;
    vec_t vecs[5];

    // transmitter model state, one slot per DUT
    int         mode[3]      = '{0, 0, 0};
    int         ack_delay[3] = '{2, 2, 2};
    int         busy_len[3]  = '{10, 10, 10};
    int         phase[3]     = '{0, 0, 0};
    int         cnt[3]       = '{0, 0, 0};
    int         rises[3]     = '{0, 0, 0};
    logic [2:0] prev_txs     = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end else begin
            $display("check %s: got %0h", name, got);
        end
    endtask

    always @(negedge clk_50mhz) begin
        for (int i = 0; i < 3; i++) begin
            if (txs[i] && !prev_txs[i]) begin
                rises[i]++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: dut%0d sent %h, expected no byte", i, txd[i]);
                end else begin
                    sb_e = exp_q.pop_front();
                    check($sformatf("sb_dut%0d_inst", i), i, sb_e.inst);
                    check($sformatf("sb_dut%0d_byte", i), {24'h0, txd[i]}, {24'h0, sb_e.data});
                end
                if (mode[i] == 0) begin
                    phase[i] = 1;
                    cnt[i]   = ack_delay[i];
                end else if (mode[i] == 2) begin
                    phase[i] = 2;
                    cnt[i]   = busy_len[i];
                end
            end else begin
                case (phase[i])
                    1: if (cnt[i] == 0) begin
                           txa[i]   = 1'b1;
                           phase[i] = 2;
                           cnt[i]   = busy_len[i];
                       end else cnt[i]--;
                    2: if (cnt[i] == 0) begin
                           txa[i]   = 1'b0;
                           phase[i] = 0;
                       end else cnt[i]--;
                    default: txa[i] = (mode[i] == 2);
                endcase
            end
            prev_txs[i] = txs[i];
        end
    end

    task automatic set_value(input int i, input logic [31:0] v);
        case (i)
            0:       value_a = v;
            1:       value_b = v;
            default: value_c = v[7:0];
        endcase
    endtask

    task automatic wait_done(input int i, input string tag);
        int c = 0;
        while (!done_w[i] && c < 500) begin
            @(negedge clk_50mhz);
            c++;
        end
        check({tag, "_done_seen"}, done_w[i], 1);
    endtask

    task automatic wait_rises(input int i, input int target, input string tag);
        int c = 0;
        while (rises[i] < target && c < 500) begin
            @(negedge clk_50mhz);
            c++;
        end
        check({tag, "_rise_seen"}, (rises[i] >= target), 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int r0;
        int i;
        i = v.inst;
        @(negedge clk_50mhz);
        mode[i]      = v.mode;
        ack_delay[i] = v.ack;
        busy_len[i]  = v.busy;
        repeat (2) @(negedge clk_50mhz);
        set_value(i, v.value);
        for (int k = 0; k < v.n; k++) exp_q.push_back('{i, v.b[k]});
        r0 = rises[i];
        act[i] = 1'b1;
        @(posedge clk_50mhz); #1;
        check({tag, "_start_latency"}, txs[i], 1);
        if (v.mode == 2) begin
            @(posedge clk_50mhz); #1;
            check({tag, "_ack_first_cycle"}, txs[i], 0);
        end
        set_value(i, ~v.value);
        wait_done(i, tag);
        check({tag, "_error"}, err_w[i], 0);
        check({tag, "_rises"}, rises[i] - r0, v.n);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
        @(negedge clk_50mhz);
        act[i] = 1'b0;
        @(posedge clk_50mhz); #1;
        check({tag, "_done_clear"}, done_w[i], 0);
        mode[i] = 0;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        vec_t rv;
        int   r0;
        vecs[0] = '{0, 32'h12345678, 0, 2, 10, 4, {8'h12, 8'h34, 8'h56, 8'h78, 8'h00}};
        vecs[1] = '{1, 32'h12345678, 0, 2, 10, 5, {8'h78, 8'h56, 8'h34, 8'h12, 8'h08}};
        vecs[2] = '{0, 32'hA5FF0001, 0, 0, 1,  4, {8'hA5, 8'hFF, 8'h00, 8'h01, 8'h00}};
        vecs[3] = '{1, 32'hDEADBEEF, 0, 1, 3,  5, {8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22}};
        vecs[4] = '{2, 32'h0000005A, 2, 1, 2,  1, {8'h5A, 8'h00, 8'h00, 8'h00, 8'h00}};

        reset = 1'b0;
        #35;
        check("reset_done", done_w, 0);
        check("reset_error", err_w, 0);
        check("reset_tx_start", txs, 0);
        check("reset_tx_data", txd, 0);
        @(negedge clk_50mhz);
        reset = 1'b1;

        for (int k = 0; k < 5; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // acknowledge timeout
        @(negedge clk_50mhz);
        mode[0] = 1;
        value_a = 32'h11223344;
        exp_q.push_back('{0, 8'h11});
        act[0] = 1'b1;
        @(posedge clk_50mhz); #1;
        check("tout_start", txs[0], 1);
        repeat (15) @(posedge clk_50mhz);
        #1;
        check("tout_done_early", done_w[0], 0);
        check("tout_start_held", txs[0], 1);
        @(posedge clk_50mhz); #1;
        check("tout_done", done_w[0], 1);
        check("tout_error", err_w[0], 1);
        check("tout_start_drop", txs[0], 0);
        @(negedge clk_50mhz);
        act[0]  = 1'b0;
        mode[0] = 0;
        @(posedge clk_50mhz); #1;
        check("tout_done_clear", done_w[0], 0);
        check("tout_error_kept", err_w[0], 1);
        run_vec(vecs[0], "after_tout");

        // activate dropped after the first byte
        @(negedge clk_50mhz);
        ack_delay[0] = 2;
        busy_len[0]  = 10;
        value_a = 32'h01020304;
        for (int k = 1; k <= 4; k++) exp_q.push_back('{0, 8'(k)});
        r0 = rises[0];
        act[0] = 1'b1;
        wait_rises(0, r0 + 1, "drop");
        act[0] = 1'b0;
        wait_done(0, "drop");
        @(negedge clk_50mhz);
        check("drop_done_one_cycle", done_w[0], 0);
        check("drop_rises", rises[0] - r0, 4);
        check("drop_sb_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk_50mhz);
        check("drop_idle_start", txs[0], 0);
        check("drop_idle_done", done_w[0], 0);

        // asynchronous reset while byte 2 awaits its acknowledge
        @(negedge clk_50mhz);
        value_a = 32'h12345678;
        exp_q.push_back('{0, 8'h12});
        exp_q.push_back('{0, 8'h34});
        r0 = rises[0];
        act[0] = 1'b1;
        wait_rises(0, r0 + 2, "rst");
        #3;
        reset = 1'b0;
        #1;
        check("rst_tx_start", txs[0], 0);
        check("rst_done", done_w[0], 0);
        check("rst_error", err_w[0], 0);
        check("rst_tx_data", {24'h0, txd[0]}, 0);
        act[0] = 1'b0;
        @(negedge clk_50mhz);
        reset = 1'b1;
        repeat (30) @(negedge clk_50mhz);
        check("rst_sb_empty", exp_q.size(), 0);
        rv = '{0, 32'hCAFEF00D, 0, 1, 4, 4, {8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h00}};
        run_vec(rv, "after_rst");

        // disabled timeout: a silent transmitter is waited for indefinitely
        @(negedge clk_50mhz);
        mode[2] = 1;
        value_c = 8'h77;
        exp_q.push_back('{2, 8'h77});
        act[2] = 1'b1;
        repeat (40) @(negedge clk_50mhz);
        check("notout_done", done_w[2], 0);
        check("notout_start_held", txs[2], 1);
        check("notout_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
